// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the divider arbiter.
// Contents: the controller state enum, the data width, the saturation
// quotients returned on divide-by-zero, and the default WAIT timeout.
package div_ctrl_pkg;

   localparam int unsigned DATA_W          = 32;
   localparam int unsigned DEFAULT_TIMEOUT = 32;

   // Saturated quotients for x/0, chosen by the sign of the dividend
   localparam logic [DATA_W-1:0] SAT_POS = 32'h7FFF_FFFF;
   localparam logic [DATA_W-1:0] SAT_NEG = 32'h8000_0001;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      DONE
   } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req   - request vector
//   ptr   - index where the search starts (wraps upward)
//   grant - one-hot winner, zero when no request
//   idx   - binary index of the winner
//   valid - at least one request is set
module rr_arbiter #(
   parameter int unsigned N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [N-1:0]         grant,
   output logic [$clog2(N)-1:0] idx,
   output logic                 valid
);

   localparam int unsigned IW = $clog2(N);

   // First set bit at or after ptr, wrapping around
   always_comb begin
      int unsigned j;
      logic [IW-1:0] jj;
      grant = '0;
      idx   = '0;
      valid = 1'b0;
      j     = 0;
      jj    = '0;
      for (int unsigned off = 0; off < N; off++) begin
         j  = (32'(ptr) + off) % N;
         jj = IW'(j);
         if (!valid && req[jj]) begin
            valid     = 1'b1;
            grant[jj] = 1'b1;
            idx       = jj;
         end
      end
   end

endmodule

// File: rtl/div_arbiter.sv
// Shares one sequential signed divider among N_REQ requesters.
// Ports:
//   CLOCK, RESET_N             - clock, async active-low reset
//   REQ, REQ_TOP, REQ_DIVISOR  - per-requester request level and operands
//   GRANT                      - one-hot requester being served
//   RESP_VALID, RESP_QUOTIENT,
//   RESP_ERR                   - one-cycle result pulse, quotient, error flag
//   BUSY                       - controller not idle
//   DIV_TOP, DIV_DIVISOR,
//   DIV_START                  - operands and start pulse to the divider
//   DIV_QUOTIENT, DIV_FINISH   - divider result and done level
module div_arbiter
   import div_ctrl_pkg::*;
#(
   parameter int unsigned N_REQ   = 4,
   parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic                    CLOCK,
   input  logic                    RESET_N,
   input  logic [N_REQ-1:0]        REQ,
   input  logic [DATA_W*N_REQ-1:0] REQ_TOP,
   input  logic [DATA_W*N_REQ-1:0] REQ_DIVISOR,
   output logic [N_REQ-1:0]        GRANT,
   output logic [N_REQ-1:0]        RESP_VALID,
   output logic [DATA_W-1:0]       RESP_QUOTIENT,
   output logic                    RESP_ERR,
   output logic                    BUSY,
   output logic [DATA_W-1:0]       DIV_TOP,
   output logic [DATA_W-1:0]       DIV_DIVISOR,
   output logic                    DIV_START,
   input  logic [DATA_W-1:0]       DIV_QUOTIENT,
   input  logic                    DIV_FINISH
);

   localparam int unsigned IW = $clog2(N_REQ);
   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   state_t          state, state_d;
   logic [IW-1:0]   ptr, ptr_d;     // next search start index
   logic [IW-1:0]   widx, widx_d;   // index of the current winner
   logic [CW-1:0]   cnt, cnt_d;     // WAIT cycles elapsed
   logic [N_REQ-1:0] grant_d, rv_d;
   logic [DATA_W-1:0] quot_d, top_d, dvs_d;
   logic            err_d, busy_d, start_d;

   logic [N_REQ-1:0] arb_grant;
   logic [IW-1:0]    arb_idx;
   logic             arb_valid;

   logic [DATA_W-1:0] top_arr [N_REQ];
   logic [DATA_W-1:0] div_arr [N_REQ];
   logic [DATA_W-1:0] sel_top, sel_div;
   logic              div_wide;

   rr_arbiter #(.N(N_REQ)) u_arb (
      .req   (REQ),
      .ptr   (ptr),
      .grant (arb_grant),
      .idx   (arb_idx),
      .valid (arb_valid)
   );

   // Unpack the requester operand buses
   for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
      assign top_arr[g] = REQ_TOP[g*DATA_W +: DATA_W];
      assign div_arr[g] = REQ_DIVISOR[g*DATA_W +: DATA_W];
   end

   assign sel_top  = top_arr[widx];
   assign sel_div  = div_arr[widx];
   // The divider only accepts divisors representable in 16 signed bits
   assign div_wide = (sel_div[31:16] != {16{sel_div[15]}});

   // Next-state and next-output logic
   always_comb begin
      state_d = state;
      ptr_d   = ptr;
      widx_d  = widx;
      cnt_d   = cnt;
      grant_d = GRANT;
      rv_d    = '0;
      quot_d  = RESP_QUOTIENT;
      err_d   = RESP_ERR;
      top_d   = DIV_TOP;
      dvs_d   = DIV_DIVISOR;
      start_d = 1'b0;
      case (state)
         IDLE: begin
            if (arb_valid) begin
               state_d = ISSUE;
               grant_d = arb_grant;
               widx_d  = arb_idx;
            end
         end
         ISSUE: begin
            top_d = sel_top;
            dvs_d = sel_div;
            cnt_d = '0;
            if (sel_div == '0) begin
               state_d = DONE;
               rv_d    = GRANT;
               err_d   = 1'b1;
               quot_d  = sel_top[DATA_W-1] ? SAT_NEG : SAT_POS;
            end else if (div_wide) begin
               state_d = DONE;
               rv_d    = GRANT;
               err_d   = 1'b1;
               quot_d  = '0;
            end else begin
               start_d = 1'b1;
               state_d = WAIT;
            end
         end
         WAIT: begin
            // First WAIT cycle may still see the previous operation's finish
            if (cnt != '0 && DIV_FINISH) begin
               state_d = DONE;
               rv_d    = GRANT;
               err_d   = 1'b0;
               quot_d  = DIV_QUOTIENT;
            end else if (cnt == CW'(TIMEOUT - 1)) begin
               state_d = DONE;
               rv_d    = GRANT;
               err_d   = 1'b1;
               quot_d  = '0;
            end else begin
               cnt_d = cnt + CW'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
            grant_d = '0;
            ptr_d   = (widx == IW'(N_REQ - 1)) ? '0 : widx + IW'(1);
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   // State and registered outputs
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         state         <= IDLE;
         ptr           <= '0;
         widx          <= '0;
         cnt           <= '0;
         GRANT         <= '0;
         RESP_VALID    <= '0;
         RESP_QUOTIENT <= '0;
         RESP_ERR      <= 1'b0;
         BUSY          <= 1'b0;
         DIV_TOP       <= '0;
         DIV_DIVISOR   <= '0;
         DIV_START     <= 1'b0;
      end else begin
         state         <= state_d;
         ptr           <= ptr_d;
         widx          <= widx_d;
         cnt           <= cnt_d;
         GRANT         <= grant_d;
         RESP_VALID    <= rv_d;
         RESP_QUOTIENT <= quot_d;
         RESP_ERR      <= err_d;
         BUSY          <= busy_d;
         DIV_TOP       <= top_d;
         DIV_DIVISOR   <= dvs_d;
         DIV_START     <= start_d;
      end
   end

endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter with a behavioural divider model
// and a scoreboard of expected responses.
module tb_div_arbiter;
   import div_ctrl_pkg::*;

   localparam int unsigned N   = 4;
   localparam int unsigned TMO = 32;
   localparam int          DLY = 18;

   logic              CLOCK = 1'b0;
   logic              RESET_N = 1'b0;
   logic [N-1:0]      REQ = '0;
   logic [32*N-1:0]   REQ_TOP = '0;
   logic [32*N-1:0]   REQ_DIVISOR = '0;
   logic [N-1:0]      GRANT, RESP_VALID;
   logic [31:0]       RESP_QUOTIENT, DIV_TOP, DIV_DIVISOR;
   logic              RESP_ERR, BUSY, DIV_START;
   logic [31:0]       DIV_QUOTIENT = 32'hDEAD_BEEF;
   logic              DIV_FINISH = 1'b1;

   typedef struct {
      logic [N-1:0] who;
      logic [31:0]  q;
      logic         err;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   n_chk = 0, n_pass = 0, n_resp = 0, n_start = 0;
   logic hang = 1'b0;
   int   dcnt = 0;
   logic dbusy = 1'b0;
   logic [31:0] dq = '0;

   div_arbiter #(.N_REQ(N), .TIMEOUT(TMO)) dut (
      .CLOCK         (CLOCK),
      .RESET_N       (RESET_N),
      .REQ           (REQ),
      .REQ_TOP       (REQ_TOP),
      .REQ_DIVISOR   (REQ_DIVISOR),
      .GRANT         (GRANT),
      .RESP_VALID    (RESP_VALID),
      .RESP_QUOTIENT (RESP_QUOTIENT),
      .RESP_ERR      (RESP_ERR),
      .BUSY          (BUSY),
      .DIV_TOP       (DIV_TOP),
      .DIV_DIVISOR   (DIV_DIVISOR),
      .DIV_START     (DIV_START),
      .DIV_QUOTIENT  (DIV_QUOTIENT),
      .DIV_FINISH    (DIV_FINISH)
   );

   always #5 CLOCK = ~CLOCK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Divider model: finish level drops one cycle after start (stale level
   // is visible in the first WAIT cycle), result appears DLY cycles later
   always @(negedge CLOCK) begin
      if (DIV_START) begin
         dq    = (DIV_DIVISOR == 0) ? 32'h0 : 32'($signed(DIV_TOP) / $signed(DIV_DIVISOR));
         dcnt  = DLY;
         dbusy = 1'b1;
      end else if (dbusy) begin
         if (dcnt == DLY) DIV_FINISH = 1'b0;
         if (dcnt > 0) dcnt--;
         if (dcnt == 0 && !hang) begin
            DIV_FINISH   = 1'b1;
            DIV_QUOTIENT = dq;
            dbusy        = 1'b0;
         end
      end
   end

   // Response monitor and scoreboard
   always @(negedge CLOCK) begin
      if (DIV_START) n_start++;
      if (RESP_VALID != '0) begin
         n_resp++;
         chk("resp_onehot", 32'($countones(RESP_VALID)), 32'd1);
         chk("grant_vs_resp", 32'(GRANT), 32'(RESP_VALID));
         if (sb.size() == 0) begin
            chk("unexpected_resp", 32'(RESP_VALID), 32'd0);
         end else begin
            e = sb.pop_front();
            chk("resp_who", 32'(RESP_VALID), 32'(e.who));
            chk("resp_quot", RESP_QUOTIENT, e.q);
            chk("resp_err", 32'(RESP_ERR), 32'(e.err));
         end
      end
   end

   function automatic exp_t mk_exp(input int r, input logic [31:0] top,
                                   input logic [31:0] dv, input logic hg);
      exp_t x;
      x.who    = '0;
      x.who[r] = 1'b1;
      if (dv == 0) begin
         x.q = top[31] ? SAT_NEG : SAT_POS;  x.err = 1'b1;
      end else if (dv[31:16] != {16{dv[15]}}) begin
         x.q = 32'h0;  x.err = 1'b1;
      end else if (hg) begin
         x.q = 32'h0;  x.err = 1'b1;
      end else begin
         x.q = 32'($signed(top) / $signed(dv));  x.err = 1'b0;
      end
      return x;
   endfunction

   task automatic chk_zero(input string tag);
      chk({tag, "_grant"}, 32'(GRANT), 32'd0);
      chk({tag, "_rv"},    32'(RESP_VALID), 32'd0);
      chk({tag, "_quot"},  RESP_QUOTIENT, 32'd0);
      chk({tag, "_err"},   32'(RESP_ERR), 32'd0);
      chk({tag, "_busy"},  32'(BUSY), 32'd0);
      chk({tag, "_top"},   DIV_TOP, 32'd0);
      chk({tag, "_dvs"},   DIV_DIVISOR, 32'd0);
      chk({tag, "_start"}, 32'(DIV_START), 32'd0);
   endtask

   task automatic wait_resp(input int k, input int budget, output int lat);
      int target;
      target = n_resp + k;
      lat = 0;
      while (n_resp < target && lat < budget) begin
         @(negedge CLOCK); #1;
         lat++;
      end
      chk("resp_arrived", 32'(n_resp), 32'(target));
   endtask

   task automatic run_op(input int r, input logic [31:0] top, input logic [31:0] dv,
                         input logic hg, input int exp_lat, input int exp_starts);
      int s0, lat;
      hang = hg;
      s0   = n_start;
      REQ_TOP[r*32 +: 32]     = top;
      REQ_DIVISOR[r*32 +: 32] = dv;
      sb.push_back(mk_exp(r, top, dv, hg));
      REQ[r] = 1'b1;
      wait_resp(1, 200, lat);
      REQ[r] = 1'b0;
      if (exp_lat >= 0) chk("latency", 32'(lat), 32'(exp_lat));
      repeat (2) @(negedge CLOCK);
      #1;
      chk("start_cnt", 32'(n_start - s0), 32'(exp_starts));
      chk("idle_busy", 32'(BUSY), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int lat;
      repeat (3) @(negedge CLOCK);
      #1;
      chk_zero("rst");
      RESET_N = 1'b1;
      @(negedge CLOCK); #1;

      // Normal and signed divisions
      run_op(0, 32'd100, 32'd7, 1'b0, -1, 1);
      run_op(0, -32'sd100, 32'd7, 1'b0, -1, 1);
      run_op(1, 32'd100, -32'sd7, 1'b0, -1, 1);
      run_op(3, 32'h7FFF_FFFF, 32'hFFFF_8000, 1'b0, -1, 1);

      // Screened operands: no start, two-cycle latency
      run_op(2, 32'd5, 32'd0, 1'b0, 2, 0);
      run_op(3, -32'sd5, 32'd0, 1'b0, 2, 0);
      run_op(1, 32'd12345, 32'h0001_0000, 1'b0, 2, 0);
      run_op(0, 32'd9, 32'hFFFF_7FFF, 1'b0, 2, 0);

      // Divider never finishes
      run_op(2, 32'd100, 32'd7, 1'b1, 2 + TMO, 1);
      hang = 1'b0;

      // Round-robin with all requesters held, pointer starting from reset
      RESET_N = 1'b0;
      @(negedge CLOCK); #1;
      chk_zero("rst2");
      RESET_N = 1'b1;
      REQ_TOP     = {32'd1000, 32'd100, -32'sd100, 32'd100};
      REQ_DIVISOR = {32'd3, -32'sd7, 32'd7, 32'd7};
      sb.push_back(mk_exp(0, 32'd100, 32'd7, 1'b0));
      sb.push_back(mk_exp(1, -32'sd100, 32'd7, 1'b0));
      sb.push_back(mk_exp(2, 32'd100, -32'sd7, 1'b0));
      sb.push_back(mk_exp(3, 32'd1000, 32'd3, 1'b0));
      sb.push_back(mk_exp(0, 32'd100, 32'd7, 1'b0));
      @(negedge CLOCK); #1;
      REQ = '1;
      wait_resp(5, 400, lat);
      REQ = '0;
      repeat (2) @(negedge CLOCK);
      #1;
      chk("rr_sb_empty", 32'(sb.size()), 32'd0);

      // Asynchronous reset in the middle of WAIT
      REQ_TOP[32 +: 32]     = 32'd77;
      REQ_DIVISOR[32 +: 32] = 32'd7;
      REQ[1] = 1'b1;
      begin
         int r0;
         r0 = n_resp;
         repeat (8) @(negedge CLOCK);
         #1;
         chk("mid_busy", 32'(BUSY), 32'd1);
         #2 RESET_N = 1'b0;
         #1;
         chk_zero("async_rst");
         REQ = '0;
         repeat (3) @(negedge CLOCK);
         #1;
         RESET_N = 1'b1;
         chk("no_resp_on_reset", 32'(n_resp), 32'(r0));
      end
      @(negedge CLOCK); #1;
      run_op(1, 32'd77, 32'd7, 1'b0, -1, 1);

      chk("final_sb_empty", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
